// File: rtl/rs232x_pkg.sv
// Shared definitions for the rs232x serial device: register map, control/status
// bit positions, parity encodings and the engine state types.
// Pure declarations; no logic, no timing.
package rs232x_pkg;

    // Register addresses on the stb/we/addr bus
    localparam logic [1:0] ADDR_DATA      = 2'd0;
    localparam logic [1:0] ADDR_STAT_CTRL = 2'd1;
    localparam logic [1:0] ADDR_DIV       = 2'd2;
    localparam logic [1:0] ADDR_CTRL      = 2'd3;

    // Parity modes (control[1:0]); the fourth code behaves like PAR_NONE
    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    // Status register bit indices
    localparam int ST_RXBNE = 0;
    localparam int ST_TXBE  = 1;
    localparam int ST_RXBF  = 2;
    localparam int ST_TXBNF = 3;
    localparam int ST_FE    = 4;
    localparam int ST_PE    = 5;
    localparam int ST_OV    = 6;

    // Control register bit indices
    localparam int CT_PAR_LO   = 0;
    localparam int CT_PAR_HI   = 1;
    localparam int CT_TWO_STOP = 2;
    localparam int CT_CLR_ERR  = 3;
    localparam int CT_FLUSH_RX = 4;
    localparam int CT_FLUSH_TX = 5;
    localparam int CT_FLOW_EN  = 6;

    // Smallest divisor the engines can work with (RX needs a usable half-bit)
    localparam logic [15:0] DIV_MIN = 16'd4;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    // Bit that makes the total count of ones even (PAR_EVEN) or odd (PAR_ODD)
    function automatic logic parity_bit(input logic [1:0] mode, input logic [7:0] d);
        return (mode == PAR_ODD) ? ~^d : ^d;
    endfunction

endpackage

// File: rtl/rs232x_fifo.sv
// Synchronous byte FIFO with SLOTS entries (power of two, >= 2), show-ahead dout.
// Latency: push visible on empty/count the next cycle; dout is the head entry combinationally.
// Backpressure: push while full is dropped unless a pop happens the same cycle; pop while empty is ignored.
module rs232x_fifo #(
    parameter int SLOTS = 64,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(SLOTS):0]   count
);
    localparam int AW = $clog2(SLOTS);

    logic [WIDTH-1:0] mem_q [SLOTS];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Next pointers; flush discards everything including a same-cycle push
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/rs232x.sv
// RS232 UART on the stb/we/addr bus: programmable divisor, parity, 1/2 stop bits, RX/TX FIFOs.
// Latency: zero-wait bus (ack = stb); TX write in cycle N puts the start bit on txd in cycle N+2.
// Backpressure: TX writes to a full FIFO are dropped, RX bytes arriving to a full FIFO set OV.
// Optional hardware flow control (cts_n/rts_n, control bit 6) with `define RS232X_HWFLOW_EN.
module rs232x
    import rs232x_pkg::*;
#(
    parameter int CLOCK_FREQ   = 50_000_000,
    parameter int DEFAULT_BAUD = 115200,
    parameter int BUF_SLOTS    = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stb,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack,
    input  logic        rxd,
    output logic        txd
`ifdef RS232X_HWFLOW_EN
    ,
    input  logic        cts_n,
    output logic        rts_n
`endif
);
    localparam int          CW        = $clog2(BUF_SLOTS) + 1;
    localparam logic [15:0] DIV_RESET = 16'(CLOCK_FREQ / DEFAULT_BAUD);

    // Bus decode
    logic rd_en, wr_en, rx_pop, tx_push, ctrl_wr, div_wr;
    logic err_clr, rx_flush, tx_flush;
    assign ack      = stb;
    assign rd_en    = stb && !we;
    assign wr_en    = stb && we;
    assign rx_pop   = rd_en && (addr == ADDR_DATA);
    assign tx_push  = wr_en && (addr == ADDR_DATA);
    assign ctrl_wr  = wr_en && (addr == ADDR_STAT_CTRL);
    assign div_wr   = wr_en && (addr == ADDR_DIV);
    assign err_clr  = ctrl_wr && data_in[CT_CLR_ERR];
    assign rx_flush = ctrl_wr && data_in[CT_FLUSH_RX];
    assign tx_flush = ctrl_wr && data_in[CT_FLUSH_TX];

    // FIFOs
    logic [7:0]    rx_dout, tx_dout, rx_din;
    logic          rx_empty, rx_full, tx_empty, tx_full, rx_push, tx_start;
    logic [CW-1:0] rx_count, tx_count;

    rs232x_fifo #(.SLOTS(BUF_SLOTS), .WIDTH(8)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .flush(rx_flush),
        .din(rx_din), .dout(rx_dout), .empty(rx_empty), .full(rx_full), .count(rx_count)
    );

    rs232x_fifo #(.SLOTS(BUF_SLOTS), .WIDTH(8)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .pop(tx_start), .flush(tx_flush),
        .din(data_in[7:0]), .dout(tx_dout), .empty(tx_empty), .full(tx_full), .count(tx_count)
    );

    // Configuration and sticky error registers
    logic [1:0]  par_q, par_d;
    logic        two_stop_q, two_stop_d;
    logic [15:0] div_q, div_d;
    logic        fe_q, fe_d, pe_q, pe_d, ov_q, ov_d;
    logic        fe_set, pe_set, ov_set;
    logic        flow_en, cts_ok;

    // Next-state for control, divisor and errors; a same-cycle set beats a clear
    always_comb begin
        par_d      = par_q;
        two_stop_d = two_stop_q;
        div_d      = div_q;
        if (ctrl_wr) begin
            par_d      = data_in[CT_PAR_HI:CT_PAR_LO];
            two_stop_d = data_in[CT_TWO_STOP];
        end
        if (div_wr) div_d = (data_in[15:0] < DIV_MIN) ? DIV_MIN : data_in[15:0];
        fe_d = fe_set | (fe_q & ~err_clr);
        pe_d = pe_set | (pe_q & ~err_clr);
        ov_d = ov_set | (ov_q & ~err_clr);
    end

    // Configuration and error flops
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q      <= PAR_NONE;
            two_stop_q <= 1'b0;
            div_q      <= DIV_RESET;
            fe_q       <= 1'b0;
            pe_q       <= 1'b0;
            ov_q       <= 1'b0;
        end else begin
            par_q      <= par_d;
            two_stop_q <= two_stop_d;
            div_q      <= div_d;
            fe_q       <= fe_d;
            pe_q       <= pe_d;
            ov_q       <= ov_d;
        end
    end

`ifdef RS232X_HWFLOW_EN
    logic flow_en_q, flow_en_d, cts_s1_q, cts_s2_q, rts_n_q, rts_n_d;
    localparam logic [CW-1:0] RTS_LEVEL = CW'(BUF_SLOTS - 2);

    // Flow enable bit, and rts_n raised once two or fewer RX slots remain
    always_comb begin
        flow_en_d = ctrl_wr ? data_in[CT_FLOW_EN] : flow_en_q;
        rts_n_d   = flow_en_q && (rx_count >= RTS_LEVEL);
    end

    // cts_n synchroniser plus flow-control flops
    always_ff @(posedge clk) begin
        if (rst) begin
            flow_en_q <= 1'b0;
            cts_s1_q  <= 1'b1;
            cts_s2_q  <= 1'b1;
            rts_n_q   <= 1'b1;
        end else begin
            flow_en_q <= flow_en_d;
            cts_s1_q  <= cts_n;
            cts_s2_q  <= cts_s1_q;
            rts_n_q   <= rts_n_d;
        end
    end

    assign flow_en = flow_en_q;
    assign cts_ok  = !flow_en_q || !cts_s2_q;
    assign rts_n   = rts_n_q;
`else
    assign flow_en = 1'b0;
    assign cts_ok  = 1'b1;
`endif

    // ---------------- TX engine ----------------
    tx_state_t   tx_state_q;
    logic        txd_q;
    logic [15:0] tx_cnt_q, tx_div_q;
    logic [2:0]  tx_bit_q;
    logic [7:0]  tx_byte_q;
    logic [1:0]  tx_par_q;
    logic        tx_two_q, tx_stop2_q;
    logic        tx_bit_end, tx_last_stop;

    assign tx_bit_end   = (tx_cnt_q == 16'd0);
    assign tx_last_stop = (tx_state_q == TX_STOP) && tx_bit_end && (!tx_two_q || tx_stop2_q);
    // A new frame starts from idle or straight out of the final stop bit (no gap)
    assign tx_start     = !tx_empty && cts_ok && ((tx_state_q == TX_IDLE) || tx_last_stop);
    assign txd          = txd_q;

    // TX frame sequencer; divisor and framing are captured when the frame starts
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            txd_q      <= 1'b1;
            tx_cnt_q   <= '0;
            tx_div_q   <= DIV_RESET;
            tx_bit_q   <= '0;
            tx_byte_q  <= '0;
            tx_par_q   <= PAR_NONE;
            tx_two_q   <= 1'b0;
            tx_stop2_q <= 1'b0;
        end else if (tx_start) begin
            tx_state_q <= TX_START;
            txd_q      <= 1'b0;
            tx_byte_q  <= tx_dout;
            tx_div_q   <= div_q;
            tx_par_q   <= par_q;
            tx_two_q   <= two_stop_q;
            tx_stop2_q <= 1'b0;
            tx_cnt_q   <= div_q - 16'd1;
        end else begin
            case (tx_state_q)
                TX_IDLE: txd_q <= 1'b1;
                TX_START: begin
                    if (tx_bit_end) begin
                        tx_state_q <= TX_DATA;
                        tx_bit_q   <= 3'd0;
                        txd_q      <= tx_byte_q[0];
                        tx_cnt_q   <= tx_div_q - 16'd1;
                    end else tx_cnt_q <= tx_cnt_q - 16'd1;
                end
                TX_DATA: begin
                    if (tx_bit_end) begin
                        tx_cnt_q <= tx_div_q - 16'd1;
                        if (tx_bit_q == 3'd7) begin
                            if (parity_enabled(tx_par_q)) begin
                                tx_state_q <= TX_PARITY;
                                txd_q      <= parity_bit(tx_par_q, tx_byte_q);
                            end else begin
                                tx_state_q <= TX_STOP;
                                txd_q      <= 1'b1;
                            end
                        end else begin
                            tx_bit_q <= tx_bit_q + 3'd1;
                            txd_q    <= tx_byte_q[tx_bit_q + 3'd1];
                        end
                    end else tx_cnt_q <= tx_cnt_q - 16'd1;
                end
                TX_PARITY: begin
                    if (tx_bit_end) begin
                        tx_state_q <= TX_STOP;
                        txd_q      <= 1'b1;
                        tx_cnt_q   <= tx_div_q - 16'd1;
                    end else tx_cnt_q <= tx_cnt_q - 16'd1;
                end
                TX_STOP: begin
                    if (tx_bit_end) begin
                        if (tx_two_q && !tx_stop2_q) begin
                            tx_stop2_q <= 1'b1;
                            tx_cnt_q   <= tx_div_q - 16'd1;
                        end else begin
                            tx_state_q <= TX_IDLE;
                            txd_q      <= 1'b1;
                        end
                    end else tx_cnt_q <= tx_cnt_q - 16'd1;
                end
                default: begin
                    tx_state_q <= TX_IDLE;
                    txd_q      <= 1'b1;
                end
            endcase
        end
    end

    // ---------------- RX engine ----------------
    rx_state_t   rx_state_q;
    logic        rx_s1_q, rx_s2_q, rx_s3_q;
    logic [15:0] rx_cnt_q, rx_div_q;
    logic [2:0]  rx_bit_q;
    logic [7:0]  rx_byte_q;
    logic [1:0]  rx_par_q;
    logic        rx_pbit_q;
    logic        rx_sample, rx_done, rx_fall;

    // rxd is asynchronous: two flops to resolve metastability, a third to find the falling edge
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
        end else begin
            rx_s1_q <= rxd;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
        end
    end

    assign rx_fall   = rx_s3_q && !rx_s2_q;
    assign rx_sample = (rx_cnt_q == 16'd0);
    assign rx_done   = (rx_state_q == RX_STOP) && rx_sample;
    assign rx_din    = rx_byte_q;
    assign rx_push   = rx_done && rx_s2_q;
    assign fe_set    = rx_done && !rx_s2_q;
    assign pe_set    = rx_push && parity_enabled(rx_par_q) && (rx_pbit_q != parity_bit(rx_par_q, rx_byte_q));
    // A read in the same cycle frees a slot, so the byte still lands
    assign ov_set    = rx_push && rx_full && !rx_pop;

    // RX frame sequencer: first sample at mid start bit, then once per bit period
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_div_q   <= DIV_RESET;
            rx_bit_q   <= '0;
            rx_byte_q  <= '0;
            rx_par_q   <= PAR_NONE;
            rx_pbit_q  <= 1'b0;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_fall) begin
                        rx_state_q <= RX_START;
                        rx_div_q   <= div_q;
                        rx_par_q   <= par_q;
                        rx_cnt_q   <= (div_q >> 1) - 16'd1;
                    end
                end
                RX_START: begin
                    if (rx_sample) begin
                        if (!rx_s2_q) begin
                            rx_state_q <= RX_DATA;
                            rx_bit_q   <= 3'd0;
                            rx_cnt_q   <= rx_div_q - 16'd1;
                        end else rx_state_q <= RX_IDLE;
                    end else rx_cnt_q <= rx_cnt_q - 16'd1;
                end
                RX_DATA: begin
                    if (rx_sample) begin
                        rx_byte_q[rx_bit_q] <= rx_s2_q;
                        rx_cnt_q            <= rx_div_q - 16'd1;
                        rx_bit_q            <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7)
                            rx_state_q <= parity_enabled(rx_par_q) ? RX_PARITY : RX_STOP;
                    end else rx_cnt_q <= rx_cnt_q - 16'd1;
                end
                RX_PARITY: begin
                    if (rx_sample) begin
                        rx_pbit_q  <= rx_s2_q;
                        rx_state_q <= RX_STOP;
                        rx_cnt_q   <= rx_div_q - 16'd1;
                    end else rx_cnt_q <= rx_cnt_q - 16'd1;
                end
                RX_STOP: begin
                    if (rx_sample) rx_state_q <= RX_IDLE;
                    else rx_cnt_q <= rx_cnt_q - 16'd1;
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // ---------------- Read mux ----------------
    logic [31:0] status, ctrl_rd;

    // Status word assembly
    always_comb begin
        status           = '0;
        status[ST_RXBNE] = !rx_empty;
        status[ST_TXBE]  = tx_empty && (tx_state_q == TX_IDLE);
        status[ST_RXBF]  = rx_full;
        status[ST_TXBNF] = !tx_full;
        status[ST_FE]    = fe_q;
        status[ST_PE]    = pe_q;
        status[ST_OV]    = ov_q;
        ctrl_rd                        = '0;
        ctrl_rd[CT_PAR_HI:CT_PAR_LO]   = par_q;
        ctrl_rd[CT_TWO_STOP]           = two_stop_q;
        ctrl_rd[CT_FLOW_EN]            = flow_en;
    end

    // Read data is combinational and zero outside a read
    always_comb begin
        data_out = '0;
        if (rd_en) begin
            case (addr)
                ADDR_DATA:      data_out = {24'd0, rx_empty ? 8'd0 : rx_dout};
                ADDR_STAT_CTRL: data_out = status;
                ADDR_DIV:       data_out = {16'd0, div_q};
                ADDR_CTRL:      data_out = ctrl_rd;
                default:        data_out = '0;
            endcase
        end
    end

    // Bits intentionally left unread
    logic unused_ok;
`ifdef RS232X_HWFLOW_EN
    assign unused_ok = ^{data_in[31:16], tx_count};
`else
    assign unused_ok = ^{data_in[31:16], tx_count, rx_count};
`endif

endmodule

// File: tb/tb_rs232x.sv
// Randomised bench for rs232x with a bit-level serial line model.
// DIV = 8 (1 MHz / 115200), four-slot FIFOs.
module tb_rs232x;
    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 115200;
    localparam int SLOTS  = 4;

    logic        clk = 1'b0;
    logic        rst, stb, we, rxd, ack, txd;
    logic [1:0]  addr;
    logic [31:0] data_in, data_out;
`ifdef RS232X_HWFLOW_EN
    logic        cts_n, rts_n;
`endif

    always #5 clk = ~clk;

    rs232x #(.CLOCK_FREQ(CLK_HZ), .DEFAULT_BAUD(BAUD), .BUF_SLOTS(SLOTS)) dut (
        .clk(clk), .rst(rst), .stb(stb), .we(we), .addr(addr), .data_in(data_in),
        .data_out(data_out), .ack(ack), .rxd(rxd), .txd(txd)
`ifdef RS232X_HWFLOW_EN
        , .cts_n(cts_n), .rts_n(rts_n)
`endif
    );

    int vectors = 0;
    int miscompares = 0;
    int cur_div = CLK_HZ / BAUD;

    // Reference state
    logic [7:0] tx_q[$];
    bit         exp_w[$];
    logic [7:0] rx_model[$];
    bit         m_fe, m_pe, m_ov;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit par_en(input logic [1:0] p);
        return (p == 2'd1) || (p == 2'd2);
    endfunction

    function automatic bit par_val(input logic [1:0] p, input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += d[i];
        return (p == 2'd1) ? bit'(ones % 2) : bit'((ones + 1) % 2);
    endfunction

    task automatic bus_idle();
        stb = 1'b0; we = 1'b0; addr = 2'd0; data_in = '0;
    endtask

    // Called at a negedge; returns at the following negedge with the bus idle
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        stb = 1'b1; we = 1'b1; addr = a; data_in = d;
        @(negedge clk);
        bus_idle();
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        stb = 1'b1; we = 1'b0; addr = a;
        #1;
        d = data_out;
        check("ack", {31'd0, ack}, 32'd1);
        @(negedge clk);
        bus_idle();
    endtask

    task automatic push_bit(input bit b, input int d);
        repeat (d) exp_w.push_back(b);
    endtask

    // Writes tx_q bytes on consecutive cycles and checks txd every cycle against
    // the expected waveform of the first nexp frames.
    task automatic run_tx(input string tag, input int nexp, input logic [1:0] par,
                          input bit two, input int div_at, input int new_div);
        exp_w.delete();
        push_bit(1'b1, 2);
        for (int f = 0; f < nexp; f++) begin
            int d;
            d = (f > 0 && div_at >= 0) ? new_div : cur_div;
            push_bit(1'b0, d);
            for (int i = 0; i < 8; i++) push_bit(tx_q[f][i], d);
            if (par_en(par)) push_bit(par_val(par, tx_q[f]), d);
            push_bit(1'b1, d);
            if (two) push_bit(1'b1, d);
        end
        push_bit(1'b1, 4);
        for (int j = 0; j < exp_w.size(); j++) begin
            if (j < tx_q.size()) begin
                stb = 1'b1; we = 1'b1; addr = 2'd0; data_in = {24'd0, tx_q[j]};
            end else if (j == div_at) begin
                stb = 1'b1; we = 1'b1; addr = 2'd2; data_in = new_div;
            end else bus_idle();
            #1;
            check(tag, {31'd0, txd}, {31'd0, exp_w[j]});
            @(negedge clk);
        end
        bus_idle();
        if (div_at >= 0) cur_div = new_div;
    endtask

    // Drives one serial frame on rxd and updates the expected RX outcome
    task automatic send_rx(input logic [7:0] d, input logic [1:0] par, input bit bad_par,
                           input bit stop_val, input bit two);
        rxd = 1'b0; repeat (cur_div) @(negedge clk);
        for (int i = 0; i < 8; i++) begin rxd = d[i]; repeat (cur_div) @(negedge clk); end
        if (par_en(par)) begin rxd = par_val(par, d) ^ bad_par; repeat (cur_div) @(negedge clk); end
        rxd = stop_val; repeat (cur_div) @(negedge clk);
        if (two) begin rxd = 1'b1; repeat (cur_div) @(negedge clk); end
        rxd = 1'b1; repeat (3) @(negedge clk);
        if (!stop_val) m_fe = 1'b1;
        else begin
            if (par_en(par) && bad_par) m_pe = 1'b1;
            if (rx_model.size() < SLOTS) rx_model.push_back(d);
            else m_ov = 1'b1;
        end
    endtask

    task automatic check_status(input string tag);
        logic [31:0] rd;
        bus_read(2'd1, rd);
        check(tag, rd, {25'd0, m_ov, m_pe, m_fe, 1'b1, rx_model.size() == SLOTS,
                        1'b1, rx_model.size() != 0});
    endtask

    task automatic drain_rx(input string tag);
        logic [31:0] rd;
        while (rx_model.size() != 0) begin
            bus_read(2'd0, rd);
            check(tag, rd, {24'd0, rx_model.pop_front()});
        end
        bus_read(2'd0, rd);
        check("rx_empty_read", rd, 32'd0);
    endtask

    task automatic clear_errors(input logic [31:0] ctrl);
        bus_write(2'd1, ctrl | 32'h8);
        m_fe = 1'b0; m_pe = 1'b0; m_ov = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  par;
        bit          two, bad, sbad;
        int          n;

        rst = 1'b1; rxd = 1'b1; bus_idle();
`ifdef RS232X_HWFLOW_EN
        cts_n = 1'b1;
`endif
        m_fe = 0; m_pe = 0; m_ov = 0;
        repeat (3) @(negedge clk);
        check("txd_in_reset", {31'd0, txd}, 32'd1);
`ifdef RS232X_HWFLOW_EN
        check("rts_n_in_reset", {31'd0, rts_n}, 32'd1);
`endif
        rst = 1'b0;
        @(negedge clk);
        check("data_out_idle", data_out, 32'd0);
        check("ack_idle", {31'd0, ack}, 32'd0);
        check_status("status_reset");
        bus_read(2'd3, rd); check("ctrl_reset", rd, 32'd0);
        bus_read(2'd2, rd); check("div_reset", rd, 32'd8);
        bus_read(2'd0, rd); check("rx_read_reset", rd, 32'd0);

        // Single 0x55 frame: start bit two cycles after the write, 8-cycle bits
        tx_q = {8'h55};
        run_tx("tx_55", 1, 2'd0, 1'b0, -1, 0);
        check_status("txbe_after_55");

        // Divisor clamp, then mid-frame divisor change
        bus_write(2'd2, 32'd2);
        bus_read(2'd2, rd); check("div_clamp", rd, 32'd4);
        bus_write(2'd2, 32'd8);
        tx_q = {8'hC3, 8'h5A};
        run_tx("tx_div_change", 2, 2'd0, 1'b0, 10, 16);
        bus_write(2'd2, 32'd8); cur_div = 8;

        // Six back-to-back writes into a four-slot FIFO: the sixth is dropped
        tx_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        run_tx("tx_full_drop", 5, 2'd0, 1'b0, -1, 0);

        // Random TX bursts with random framing
        for (int it = 0; it < 4; it++) begin
            par = 2'($urandom_range(0, 3));
            two = bit'($urandom_range(0, 1));
            bus_write(2'd1, {29'd0, two, par});
            n = $urandom_range(1, 4);
            tx_q.delete();
            for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom));
            run_tx("tx_random", n, par, two, -1, 0);
        end
        check_status("txbe_after_random");

        // Even parity, 0xA3 with a wrong parity bit
        bus_write(2'd1, 32'h1);
        send_rx(8'hA3, 2'd1, 1'b1, 1'b1, 1'b0);
        check_status("pe_set");
        drain_rx("rx_a3");
        clear_errors(32'h1);
        check_status("pe_cleared");

        // Framing error and a one-cycle glitch
        bus_write(2'd1, 32'h0);
        send_rx(8'h3C, 2'd0, 1'b0, 1'b0, 1'b0);
        check_status("fe_set");
        clear_errors(32'h0);
        rxd = 1'b0; @(negedge clk); rxd = 1'b1;
        repeat (20) @(negedge clk);
        check_status("glitch_ignored");

        // Overrun: five frames into four slots
        for (int k = 1; k <= 5; k++) send_rx(8'(k * 8'h11), 2'd0, 1'b0, 1'b1, 1'b0);
        check_status("overrun");
        drain_rx("rx_overrun_order");
        clear_errors(32'h0);

        // Random RX batches
        for (int it = 0; it < 5; it++) begin
            par = 2'($urandom_range(0, 3));
            two = bit'($urandom_range(0, 1));
            clear_errors({29'd0, two, par});
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                bad  = par_en(par) && ($urandom_range(0, 3) == 0);
                sbad = ($urandom_range(0, 4) == 0);
                send_rx(8'($urandom), par, bad, !sbad, two);
            end
            check_status("rx_random_status");
            drain_rx("rx_random_data");
        end
        clear_errors(32'h0);

`ifdef RS232X_HWFLOW_EN
        bus_write(2'd1, 32'h40);
        @(negedge clk);
        check("rts_n_flow_empty", {31'd0, rts_n}, 32'd0);
        bus_write(2'd0, 32'h41);
        for (int k = 0; k < 10; k++) begin
            check("cts_hold", {31'd0, txd}, 32'd1);
            @(negedge clk);
        end
        cts_n = 1'b0;
        @(negedge clk); check("cts_sync1", {31'd0, txd}, 32'd1);
        @(negedge clk); check("cts_sync2", {31'd0, txd}, 32'd1);
        @(negedge clk); check("cts_start", {31'd0, txd}, 32'd0);
        repeat (100) @(negedge clk);
        bus_write(2'd1, 32'h0);
        cts_n = 1'b1;
`endif

        // Reset in the middle of a frame
        bus_write(2'd0, 32'h00);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("txd_reset_midframe", {31'd0, txd}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        cur_div = 8;
        check_status("status_after_reset");
        bus_read(2'd2, rd); check("div_after_reset", rd, 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
